// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Controller for a direct-mapped instruction cache array with asynchronous read
// and synchronous write. Fetch lookups resolve as hits in the same cycle. A miss
// refills the line one 32-bit word at a time from memory, then writes the tag
// and data to the array in one cycle. A full invalidate sweep runs after reset
// and on every flush request.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   inst_req, inst_addr_in      fetch request and byte address
//   inst_ready, inst_data       hit indication and fetched word (same cycle)
//   busy                        controller is refilling, writing or sweeping
//   flush, flush_done           invalidate request / sweep-complete pulse
//   mem_req, mem_addr           memory word-read request and word address
//   mem_ack, mem_rdata          memory response
//   cache_we, cache_addr        array write enable and line index
//   cache_tag_in, cache_data_in array write data ({valid, tag} and line)
//   cache_tag_out, cache_data_out array read data (asynchronous)
// -----------------------------------------------------------------------------
module icache_ctrl #(
    parameter int INDEX_W    = 10,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inst_req,
    input  logic [31:0]              inst_addr_in,
    output logic                     inst_ready,
    output logic [31:0]              inst_data,
    output logic                     busy,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     cache_we,
    output logic [INDEX_W-1:0]       cache_addr,
    output logic [TAG_W:0]           cache_tag_in,
    output logic [32*LINE_WORDS-1:0] cache_data_in,
    input  logic [TAG_W:0]           cache_tag_out,
    input  logic [32*LINE_WORDS-1:0] cache_data_out
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int LINE_W = 32 - OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_INVAL
    } state_t;

    state_t              state_q;
    logic [LINE_W-1:0]   line_q;     // latched line address of the refill
    logic [WORD_W-1:0]   wcnt_q;     // refill word counter
    logic [INDEX_W-1:0]  icnt_q;     // invalidate sweep index
    logic                pend_q;     // flush seen while refilling
    logic                hold_q;     // first cycle after reset release
    logic [31:0]         buf_q [LINE_WORDS];
    logic [32*LINE_WORDS-1:0] buf_flat;

    // Byte offset bits never matter for a word fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^inst_addr_in[1:0];

    // Request address fields.
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [WORD_W-1:0]  req_word;
    assign req_tag  = inst_addr_in[31 -: TAG_W];
    assign req_idx  = inst_addr_in[OFF_W +: INDEX_W];
    assign req_word = inst_addr_in[2 +: WORD_W];

    // Latched line fields: the line address is {tag, index}.
    logic [INDEX_W-1:0] line_idx;
    logic [TAG_W-1:0]   line_tag;
    assign line_idx = line_q[INDEX_W-1:0];
    assign line_tag = line_q[LINE_W-1 -: TAG_W];

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_buf
            assign buf_flat[32*gi +: 32] = buf_q[gi];
        end
    endgenerate

    // Outputs are forced quiet while reset is asserted and during the
    // release cycle, so nothing leaks from a half-finished refill.
    logic active;
    logic hit;
    logic sweep_last;
    assign active     = rst_n & ~hold_q;
    assign hit        = active & (state_q == ST_IDLE) & inst_req &
                        cache_tag_out[TAG_W] & (cache_tag_out[TAG_W-1:0] == req_tag);
    assign sweep_last = (icnt_q == {INDEX_W{1'b1}});

    always_comb begin
        inst_ready    = 1'b0;
        inst_data     = '0;
        flush_done    = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        cache_we      = 1'b0;
        cache_addr    = '0;
        cache_tag_in  = '0;
        cache_data_in = '0;
        busy          = ~rst_n | hold_q | (state_q != ST_IDLE);
        if (active) begin
            case (state_q)
                ST_IDLE: begin
                    cache_addr = req_idx;
                    inst_ready = hit;
                    inst_data  = cache_data_out[32*req_word +: 32];
                end
                ST_FETCH: begin
                    cache_addr = line_idx;
                    mem_req    = 1'b1;
                    mem_addr   = {line_q, wcnt_q, 2'b00};
                end
                ST_WRITE: begin
                    cache_we      = 1'b1;
                    cache_addr    = line_idx;
                    cache_tag_in  = {1'b1, line_tag};
                    cache_data_in = buf_flat;
                end
                ST_INVAL: begin
                    cache_we   = 1'b1;
                    cache_addr = icnt_q;
                    flush_done = sweep_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INVAL;
            icnt_q  <= '0;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else if (hold_q) begin
            hold_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Flush wins over a simultaneous miss; the miss is
                    // retried by the lookup once the sweep is done.
                    if (flush || pend_q) begin
                        state_q <= ST_INVAL;
                        icnt_q  <= '0;
                        pend_q  <= 1'b0;
                    end else if (inst_req && !hit) begin
                        line_q  <= inst_addr_in[31:OFF_W];
                        wcnt_q  <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (flush) begin
                        pend_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        buf_q[wcnt_q] <= mem_rdata;
                        wcnt_q        <= wcnt_q + 1'b1;
                        if (wcnt_q == WORD_W'(LINE_WORDS - 1)) begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (flush || pend_q) begin
                        state_q <= ST_INVAL;
                        icnt_q  <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_INVAL: begin
                    // A flush arriving mid-sweep is covered by this sweep.
                    pend_q <= 1'b0;
                    icnt_q <= icnt_q + 1'b1;
                    if (sweep_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_INVAL;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
// Bench for icache_ctrl: models the cache array (async read, sync write) and a
// memory that returns the requested word address as data. Expected memory
// addresses, array writes and fetch data are queued when a fetch is issued and
// compared as the controller produces them.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

    localparam int INDEX_W    = 10;
    localparam int LINE_WORDS = 8;
    localparam int TAG_W      = 17;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     inst_req = 1'b0;
    logic [31:0]              inst_addr_in = '0;
    logic                     inst_ready;
    logic [31:0]              inst_data;
    logic                     busy;
    logic                     flush = 1'b0;
    logic                     flush_done;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic                     mem_ack = 1'b0;
    logic [31:0]              mem_rdata = '0;
    logic                     cache_we;
    logic [INDEX_W-1:0]       cache_addr;
    logic [TAG_W:0]           cache_tag_in;
    logic [32*LINE_WORDS-1:0] cache_data_in;
    logic [TAG_W:0]           cache_tag_out;
    logic [32*LINE_WORDS-1:0] cache_data_out;

    icache_ctrl #(.INDEX_W(INDEX_W), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr_in(inst_addr_in),
        .inst_ready(inst_ready), .inst_data(inst_data),
        .busy(busy), .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_tag_in(cache_tag_in), .cache_data_in(cache_data_in),
        .cache_tag_out(cache_tag_out), .cache_data_out(cache_data_out)
    );

    always #5 clk = ~clk;

    // Cache array model.
    logic [TAG_W:0]           tag_mem  [1 << INDEX_W];
    logic [32*LINE_WORDS-1:0] data_mem [1 << INDEX_W];
    assign cache_tag_out  = tag_mem[cache_addr];
    assign cache_data_out = data_mem[cache_addr];
    always @(posedge clk) begin
        if (cache_we) begin
            tag_mem[cache_addr]  <= cache_tag_in;
            data_mem[cache_addr] <= cache_data_in;
        end
    end

    typedef struct {
        logic [INDEX_W-1:0]       idx;
        logic [TAG_W:0]           tag;
        logic [32*LINE_WORDS-1:0] data;
    } wr_t;

    logic [31:0] exp_mem_q  [$];
    wr_t         exp_wr_q   [$];
    logic [31:0] exp_data_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0;
    int ack_period = 1;
    bit spurious = 1'b0;
    int ack_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_wr_cnt = 0;
    int sweep_idx = 0;
    int sweep_len = 0;
    int sweep_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Memory responder and array-write monitor, evaluated just after each edge.
    logic [31:0] resp_exp;
    wr_t         resp_wr;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_ack   = 1'b0;
            sweep_idx = 0;
            sweep_len = 0;
            sweep_bad = 0;
        end else begin
            if (mem_req) begin
                if ((cyc % ack_period) == 0) begin
                    if (exp_mem_q.size() == 0) begin
                        check_val("mem_req_unexp", mem_req, 0);
                    end else begin
                        resp_exp = exp_mem_q.pop_front();
                        check_val("mem_addr", mem_addr, resp_exp);
                    end
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr;
                    ack_cnt++;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = '0;
                end
            end else begin
                mem_ack   = spurious;
                mem_rdata = 32'hDEAD_BEEF;
            end
            if (cache_we) begin
                if (cache_tag_in == '0) begin
                    if (cache_addr != sweep_idx[INDEX_W-1:0] || cache_data_in != '0) sweep_bad++;
                    sweep_idx++;
                    sweep_len++;
                end else if (exp_wr_q.size() == 0) begin
                    check_val("we_unexp", cache_we, 0);
                end else begin
                    resp_wr = exp_wr_q.pop_front();
                    check_val("wr_idx", cache_addr, resp_wr.idx);
                    check_val("wr_tag", cache_tag_in, resp_wr.tag);
                    check_val("wr_data", cache_data_in, resp_wr.data);
                    wr_cnt++;
                end
            end
            if (flush_done) begin
                check_val("sweep_len", sweep_len, 1024);
                check_val("sweep_order", sweep_bad, 0);
                done_cnt++;
                done_wr_cnt = wr_cnt;
                sweep_idx = 0;
                sweep_len = 0;
                sweep_bad = 0;
            end
        end
    end

    task automatic push_miss(input logic [31:0] addr);
        logic [31:0] line;
        logic [32*LINE_WORDS-1:0] d;
        wr_t w;
        line = addr & ~32'h1F;
        for (int i = 0; i < LINE_WORDS; i++) begin
            exp_mem_q.push_back(line + 32'(4 * i));
            d[32*i +: 32] = line + 32'(4 * i);
        end
        w.idx  = addr[14:5];
        w.tag  = {1'b1, addr[31:15]};
        w.data = d;
        exp_wr_q.push_back(w);
    endtask

    task automatic wait_hit(input string tag, input int exp_lat, input bit chk_lat, input int bound);
        int n;
        bit got;
        logic [31:0] e;
        n = 0;
        got = 1'b0;
        while (n < bound) begin
            @(negedge clk);
            if (inst_ready) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        if (!got) begin
            check_val({tag, "_timeout"}, inst_ready, 1);
            exp_data_q.delete();
        end else begin
            e = exp_data_q.pop_front();
            check_val({tag, "_data"}, inst_data, e);
            if (chk_lat) check_val({tag, "_lat"}, n, exp_lat);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input bit miss);
        @(posedge clk);
        #1;
        inst_req = 1'b1;
        inst_addr_in = addr;
        if (miss) push_miss(addr);
        exp_data_q.push_back(addr & ~32'h3);
        wait_hit(tag, miss ? 10 : 0, 1'b1, 200);
        if (!miss) check_val({tag, "_memreq"}, mem_req, 0);
        $display("fetch %s addr=%08h miss=%0d data=%08h", tag, addr, miss, inst_data);
        @(posedge clk);
        #1;
        inst_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_idle"}, busy, 0);
    endtask

    int base_done;
    int base_wr;
    int base_ack;
    int n_wait;

    initial begin
        // Reset state.
        repeat (4) @(negedge clk);
        check_val("rst_busy", busy, 1);
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_we", cache_we, 0);
        check_val("rst_ready", inst_ready, 0);
        check_val("rst_done", flush_done, 0);
        rst_n = 1'b1;

        // Power-on sweep.
        wait_idle("t1", 1200);
        check_val("t1_done_cnt", done_cnt, 1);
        $display("sweep after reset done_cnt=%0d", done_cnt);

        // Cold miss, then a hit in the same line.
        fetch("t2_miss", 32'h0000_1024, 1'b1);
        fetch("t3_hit", 32'h0000_103C, 1'b0);

        // Conflict on index 0x081 evicts and re-misses.
        fetch("t4_conflict", 32'h0000_9024, 1'b1);
        fetch("t4_remiss", 32'h0000_1024, 1'b1);

        // Flush mid-refill with slow memory and spurious acks; a second flush
        // during the sweep must be absorbed.
        ack_period = 3;
        spurious = 1'b1;
        base_done = done_cnt;
        base_wr = wr_cnt;
        @(posedge clk);
        #1;
        inst_req = 1'b1;
        inst_addr_in = 32'h0000_9024;
        push_miss(32'h0000_9024);
        push_miss(32'h0000_9024);
        exp_data_q.push_back(32'h0000_9024);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (300) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_hit("t5_flush", 0, 1'b0, 1500);
        check_val("t5_one_sweep", done_cnt, base_done + 1);
        check_val("t5_wr_before_sweep", done_wr_cnt, base_wr + 1);
        check_val("t5_two_refills", wr_cnt, base_wr + 2);
        $display("flush during refill done_cnt=%0d writes=%0d", done_cnt - base_done, wr_cnt - base_wr);
        @(posedge clk);
        #1;
        inst_req = 1'b0;
        ack_period = 1;
        spurious = 1'b0;

        // Reset in the middle of a refill.
        base_done = done_cnt;
        base_wr = wr_cnt;
        @(posedge clk);
        #1;
        inst_req = 1'b1;
        inst_addr_in = 32'h0000_1024;
        push_miss(32'h0000_1024);
        exp_data_q.push_back(32'h0000_1024);
        base_ack = ack_cnt;
        n_wait = 0;
        while (ack_cnt < base_ack + 3 && n_wait < 100) begin
            @(posedge clk);
            #2;
            n_wait++;
        end
        check_val("t6_acks", ack_cnt, base_ack + 3);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        inst_req = 1'b0;
        #1 check_val("t6_req_in_rst", mem_req, 0);
        @(negedge clk);
        check_val("t6_req_after_edge", mem_req, 0);
        check_val("t6_we_after_edge", cache_we, 0);
        check_val("t6_busy", busy, 1);
        repeat (2) @(negedge clk);
        exp_mem_q.delete();
        exp_wr_q.delete();
        exp_data_q.delete();
        rst_n = 1'b1;
        wait_idle("t6", 1200);
        check_val("t6_one_sweep", done_cnt, base_done + 1);
        check_val("t6_no_write", wr_cnt, base_wr);
        check_val("t6_idx81_clear", tag_mem[10'h081], 0);
        $display("reset mid-refill done_cnt=%0d writes=%0d", done_cnt - base_done, wr_cnt - base_wr);
        fetch("t6_refetch", 32'h0000_1024, 1'b1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
